// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared definitions for the VGA/VESA timing generator:
//   - mode constants for SVGA 800x600@60, VGA 640x480@60, XGA 1024x768@60
//   - total() : sum of the four regions of one axis
//   - cnt_w_fits() : checks that an axis total fits in a counter of a given width
//   - vga_ctrl_t : the registered single-bit outputs of the generator
package vga_timing_pkg;

    // SVGA 800x600@60 (40 MHz pixel clock), the generator defaults
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;

    // VGA 640x480@60 (25.175 MHz pixel clock), syncs active-low
    localparam int VGA_H_ACTIVE  = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_V_ACTIVE  = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;

    // XGA 1024x768@60 (65 MHz pixel clock), syncs active-low
    localparam int XGA_H_ACTIVE  = 1024;
    localparam int XGA_H_FP      = 24;
    localparam int XGA_H_SYNC    = 136;
    localparam int XGA_H_BP      = 160;
    localparam int XGA_V_ACTIVE  = 768;
    localparam int XGA_V_FP      = 3;
    localparam int XGA_V_SYNC    = 6;
    localparam int XGA_V_BP      = 29;

    // Registered control outputs, kept together so reset/hold is one assignment
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic line_start;
        logic frame_start;
        logic vblank_start;
    } vga_ctrl_t;

    function automatic int total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // A counter of width w reaches values 0..2^w-1, so a period of exactly 2^w still fits
    function automatic bit cnt_w_fits(input int tot, input int w);
        return longint'(tot) <= (longint'(1) << w);
    endfunction

endpackage

// File: rtl/timing_axis.sv
// timing_axis
// One axis (horizontal or vertical) of the timing generator: a free-running
// counter over ACTIVE+FP+SYNC+BP positions plus region decodes of the current
// (pre-increment) count. Region order is active, front porch, sync, back porch.
// Ports:
//   clk         clock
//   rst_i       synchronous active-high reset, dominates step_i
//   step_i      advance the counter by one position
//   cnt_o       current position
//   wrap_o      step_i while at the last position (counter returns to 0 next)
//   in_active_o position lies in [0, ACTIVE)
//   in_sync_o   position lies in [ACTIVE+FP, ACTIVE+FP+SYNC)
module timing_axis
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 800,
    parameter int FP     = 40,
    parameter int SYNC   = 128,
    parameter int BP     = 88,
    parameter int W      = 11
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         step_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o,
    output logic         in_active_o,
    output logic         in_sync_o
);

    localparam int TOTAL   = total(ACTIVE, FP, SYNC, BP);
    localparam int LAST    = TOTAL - 1;
    localparam int SYNC_LO = ACTIVE + FP;
    localparam int SYNC_HI = ACTIVE + FP + SYNC;

    // Porches may be empty; the active and sync regions may not.
    if (ACTIVE < 1 || SYNC < 1 || FP < 0 || BP < 0) begin : g_bad_region
        $error("timing_axis: ACTIVE and SYNC must be >= 1, porches >= 0");
    end
    if (!cnt_w_fits(TOTAL, W)) begin : g_bad_width
        $error("timing_axis: axis total does not fit in the counter width");
    end

    logic [W-1:0] cnt_q, cnt_d;

    assign wrap_o = step_i && (cnt_q == W'(LAST));

    always_comb begin
        cnt_d = cnt_q;
        if (step_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign in_active_o = 32'(cnt_q) < ACTIVE;
    assign in_sync_o   = (32'(cnt_q) >= SYNC_LO) && (32'(cnt_q) < SYNC_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VESA-style sync generator. Two timing_axis instances hold the
// horizontal and vertical position; every output is a registered decode of the
// position before it advances, so all pins share one ce-cycle of latency and
// stay mutually aligned.
// Ports:
//   clk          pixel/system clock
//   RST          synchronous active-high reset, dominates ce
//   ce           pixel enable; timing and outputs advance only when high
//   hsync/vsync  syncs at HSYNC_POL/VSYNC_POL active level
//   de           active-area data enable
//   x, y         active-area coordinates, 0 outside the active area
//   line_start   one-clk strobe at the first pixel of each line
//   frame_start  one-clk strobe at pixel (0,0)
//   vblank_start one-clk strobe at the first pixel of line V_ACTIVE
//   frame_cnt    number of completed frames, wraps at 2^FRAME_W
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = SVGA_H_ACTIVE,
    parameter int H_FP      = SVGA_H_FP,
    parameter int H_SYNC    = SVGA_H_SYNC,
    parameter int H_BP      = SVGA_H_BP,
    parameter int V_ACTIVE  = SVGA_V_ACTIVE,
    parameter int V_FP      = SVGA_V_FP,
    parameter int V_SYNC    = SVGA_V_SYNC,
    parameter int V_BP      = SVGA_V_BP,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1,
    parameter int CNT_W     = 11,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               ce,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               line_start,
    output logic               frame_start,
    output logic               vblank_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_wrap, h_act, h_sync;
    logic             v_wrap, v_act, v_sync;

    timing_axis #(
        .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .W (CNT_W)
    ) u_h (
        .clk         (clk),
        .rst_i       (RST),
        .step_i      (ce),
        .cnt_o       (h_cnt),
        .wrap_o      (h_wrap),
        .in_active_o (h_act),
        .in_sync_o   (h_sync)
    );

    // h_wrap already implies ce, so the vertical axis moves once per line
    timing_axis #(
        .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .W (CNT_W)
    ) u_v (
        .clk         (clk),
        .rst_i       (RST),
        .step_i      (h_wrap),
        .cnt_o       (v_cnt),
        .wrap_o      (v_wrap),
        .in_active_o (v_act),
        .in_sync_o   (v_sync)
    );

    vga_ctrl_t          ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
    // frm_q counts frames as the counters wrap; fcnt_q is its pin register,
    // one ce-cycle later, so the new count appears together with frame_start.
    logic [FRAME_W-1:0] frm_q, frm_d, fcnt_q, fcnt_d;

    logic h_zero, v_zero, v_blank_line, de_now;

    assign h_zero       = (h_cnt == '0);
    assign v_zero       = (v_cnt == '0);
    assign v_blank_line = (32'(v_cnt) == V_ACTIVE);
    assign de_now       = h_act && v_act;

    always_comb begin
        ctrl_d              = ctrl_q;
        ctrl_d.line_start   = 1'b0;
        ctrl_d.frame_start  = 1'b0;
        ctrl_d.vblank_start = 1'b0;
        x_d                 = x_q;
        y_d                 = y_q;
        fcnt_d              = fcnt_q;
        frm_d               = frm_q + FRAME_W'(v_wrap);
        if (ce) begin
            ctrl_d.hsync        = h_sync ? HS_ON : ~HS_ON;
            ctrl_d.vsync        = v_sync ? VS_ON : ~VS_ON;
            ctrl_d.de           = de_now;
            ctrl_d.line_start   = h_zero;
            ctrl_d.frame_start  = h_zero && v_zero;
            ctrl_d.vblank_start = h_zero && v_blank_line;
            x_d                 = de_now ? h_cnt : '0;
            y_d                 = de_now ? v_cnt : '0;
            fcnt_d              = frm_q;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            ctrl_q.hsync        <= ~HS_ON;
            ctrl_q.vsync        <= ~VS_ON;
            ctrl_q.de           <= 1'b0;
            ctrl_q.line_start   <= 1'b0;
            ctrl_q.frame_start  <= 1'b0;
            ctrl_q.vblank_start <= 1'b0;
            x_q                 <= '0;
            y_q                 <= '0;
            frm_q               <= '0;
            fcnt_q              <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            x_q    <= x_d;
            y_q    <= y_d;
            frm_q  <= frm_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign hsync        = ctrl_q.hsync;
    assign vsync        = ctrl_q.vsync;
    assign de           = ctrl_q.de;
    assign line_start   = ctrl_q.line_start;
    assign frame_start  = ctrl_q.frame_start;
    assign vblank_start = ctrl_q.vblank_start;
    assign x            = x_q;
    assign y            = y_q;
    assign frame_cnt    = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Three generators share clk/RST/ce: a small positive-polarity mode, the same
// mode with negative polarity, and a tiny zero-porch mode with a narrow counter
// and a 2-bit frame counter. A reference model tracks each one as a linear pixel
// index within the frame plus a completed-frame count and derives the expected
// pins arithmetically from the mode description.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [10:0] x;
        logic [10:0] y;
        logic        ls;
        logic        fs;
        logic        vbs;
        logic [7:0]  fc;
    } out_t;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        bit hp, vp;
        int fw;
    } mode_t;

    logic clk = 1'b0;
    logic RST = 1'b1;
    logic ce  = 1'b0;

    always #5 clk = ~clk;

    logic        hs0, vs0, de0, ls0, fs0, vb0;
    logic [10:0] x0, y0;
    logic [7:0]  fc0;
    logic        hs1, vs1, de1, ls1, fs1, vb1;
    logic [10:0] x1, y1;
    logic [7:0]  fc1;
    logic        hs2, vs2, de2, ls2, fs2, vb2;
    logic [2:0]  x2, y2;
    logic [1:0]  fc2;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1), .VSYNC_POL(1), .CNT_W(11), .FRAME_W(8)
    ) u_dut0 (
        .clk(clk), .RST(RST), .ce(ce), .hsync(hs0), .vsync(vs0), .de(de0),
        .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0),
        .vblank_start(vb0), .frame_cnt(fc0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(0), .VSYNC_POL(0), .CNT_W(11), .FRAME_W(8)
    ) u_dut1 (
        .clk(clk), .RST(RST), .ce(ce), .hsync(hs1), .vsync(vs1), .de(de1),
        .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1),
        .vblank_start(vb1), .frame_cnt(fc1)
    );

    vga_timing_gen #(
        .H_ACTIVE(5), .H_FP(0), .H_SYNC(1), .H_BP(0),
        .V_ACTIVE(3), .V_FP(0), .V_SYNC(2), .V_BP(0),
        .HSYNC_POL(1), .VSYNC_POL(0), .CNT_W(3), .FRAME_W(2)
    ) u_dut2 (
        .clk(clk), .RST(RST), .ce(ce), .hsync(hs2), .vsync(vs2), .de(de2),
        .x(x2), .y(y2), .line_start(ls2), .frame_start(fs2),
        .vblank_start(vb2), .frame_cnt(fc2)
    );

    out_t act [3];

    always_comb begin
        act[0].hs = hs0; act[0].vs = vs0; act[0].de = de0; act[0].x = x0; act[0].y = y0;
        act[0].ls = ls0; act[0].fs = fs0; act[0].vbs = vb0; act[0].fc = fc0;
        act[1].hs = hs1; act[1].vs = vs1; act[1].de = de1; act[1].x = x1; act[1].y = y1;
        act[1].ls = ls1; act[1].fs = fs1; act[1].vbs = vb1; act[1].fc = fc1;
        act[2].hs = hs2; act[2].vs = vs2; act[2].de = de2; act[2].x = 11'(x2); act[2].y = 11'(y2);
        act[2].ls = ls2; act[2].fs = fs2; act[2].vbs = vb2; act[2].fc = 8'(fc2);
    end

    // ---------------- reference model ----------------
    mode_t md [3];
    out_t  exp_o [3];
    int    pos [3];
    int    frames [3];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int frame_len(input mode_t m);
        return (m.ha + m.hf + m.hs + m.hb) * (m.va + m.vf + m.vs + m.vb);
    endfunction

    function automatic out_t rst_out(input mode_t m);
        out_t o;
        o     = '0;
        o.hs  = ~m.hp;
        o.vs  = ~m.vp;
        return o;
    endfunction

    // Pins for a given linear position p (row-major over the full frame)
    function automatic out_t ref_out(input mode_t m, input int p, input int nfr);
        out_t o;
        int   ht, h, v;
        ht    = m.ha + m.hf + m.hs + m.hb;
        h     = p % ht;
        v     = p / ht;
        o.hs  = (h >= m.ha + m.hf && h < m.ha + m.hf + m.hs) ? m.hp : ~m.hp;
        o.vs  = (v >= m.va + m.vf && v < m.va + m.vf + m.vs) ? m.vp : ~m.vp;
        o.de  = (h < m.ha) && (v < m.va);
        o.x   = o.de ? 11'(h) : 11'd0;
        o.y   = o.de ? 11'(v) : 11'd0;
        o.ls  = (h == 0);
        o.fs  = (p == 0);
        o.vbs = (h == 0) && (v == m.va);
        o.fc  = 8'(nfr % (1 << m.fw));
        return o;
    endfunction

    task automatic model_step(input bit r, input bit c);
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                exp_o[i]  = rst_out(md[i]);
                pos[i]    = 0;
                frames[i] = 0;
            end else if (c) begin
                exp_o[i] = ref_out(md[i], pos[i], frames[i]);
                pos[i]++;
                if (pos[i] == frame_len(md[i])) begin
                    pos[i] = 0;
                    frames[i]++;
                end
            end else begin
                exp_o[i].ls  = 1'b0;
                exp_o[i].fs  = 1'b0;
                exp_o[i].vbs = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("m%0d.hsync", i),        32'(act[i].hs),  32'(exp_o[i].hs));
            chk($sformatf("m%0d.vsync", i),        32'(act[i].vs),  32'(exp_o[i].vs));
            chk($sformatf("m%0d.de", i),           32'(act[i].de),  32'(exp_o[i].de));
            chk($sformatf("m%0d.x", i),            32'(act[i].x),   32'(exp_o[i].x));
            chk($sformatf("m%0d.y", i),            32'(act[i].y),   32'(exp_o[i].y));
            chk($sformatf("m%0d.line_start", i),   32'(act[i].ls),  32'(exp_o[i].ls));
            chk($sformatf("m%0d.frame_start", i),  32'(act[i].fs),  32'(exp_o[i].fs));
            chk($sformatf("m%0d.vblank_start", i), 32'(act[i].vbs), 32'(exp_o[i].vbs));
            chk($sformatf("m%0d.frame_cnt", i),    32'(act[i].fc),  32'(exp_o[i].fc));
        end
    endtask

    // Inputs change at the falling edge; outputs are checked 1 time unit after the rising edge.
    task automatic step(input bit r, input bit c);
        RST = r;
        ce  = c;
        @(posedge clk);
        model_step(r, c);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    // ---------------- waveform measurement helpers ----------------
    function automatic int first_from(input logic [199:0] v, input int from, input logic val);
        for (int k = from; k < 200; k++) begin
            if (v[k] == val) return k;
        end
        return -1;
    endfunction

    function automatic int run_len(input logic [199:0] v, input int from, input logic val);
        int n;
        n = 0;
        for (int k = from; k < 200; k++) begin
            if (v[k] != val) return n;
            n++;
        end
        return n;
    endfunction

    logic [199:0] l_hs0, l_vs0, l_de0, l_ls0, l_fs0, l_vb0, l_hs1, l_vs1;
    int           l_x0 [200];
    int           l_fc0 [200];

    initial begin
        int   found;
        logic [7:0] fc_before;

        md[0] = '{ha:8, hf:2, hs:2, hb:2, va:4, vf:1, vs:1, vb:1, hp:1'b1, vp:1'b1, fw:8};
        md[1] = '{ha:8, hf:2, hs:2, hb:2, va:4, vf:1, vs:1, vb:1, hp:1'b0, vp:1'b0, fw:8};
        md[2] = '{ha:5, hf:0, hs:1, hb:0, va:3, vf:0, vs:2, vb:0, hp:1'b1, vp:1'b0, fw:2};

        @(negedge clk);
        // Reset values, RST dominating ce
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);

        // Continuous ce=1 from reset release: log the small modes for timing checks
        for (int k = 0; k < 200; k++) begin
            step(1'b0, 1'b1);
            l_hs0[k] = act[0].hs; l_vs0[k] = act[0].vs; l_de0[k] = act[0].de;
            l_ls0[k] = act[0].ls; l_fs0[k] = act[0].fs; l_vb0[k] = act[0].vbs;
            l_hs1[k] = act[1].hs; l_vs1[k] = act[1].vs;
            l_x0[k]  = int'(act[0].x);
            l_fc0[k] = int'(act[0].fc);
        end
        chk("pos.fs_first",     32'(l_fs0[0]), 32'd1);
        chk("pos.de_run",       first_from(l_de0, 0, 1'b0), 32'd8);
        chk("pos.x_last",       l_x0[7], 32'd7);
        chk("pos.de_gap",       first_from(l_de0, 8, 1'b1), 32'd14);
        chk("pos.hs_start",     first_from(l_hs0, 0, 1'b1), 32'd10);
        chk("pos.hs_width",     run_len(l_hs0, 10, 1'b1), 32'd2);
        chk("pos.line_period",  first_from(l_ls0, 1, 1'b1), 32'd14);
        chk("pos.vblank_at",    first_from(l_vb0, 0, 1'b1), 32'd56);
        chk("pos.vs_start",     first_from(l_vs0, 0, 1'b1), 32'd70);
        chk("pos.vs_width",     run_len(l_vs0, 70, 1'b1), 32'd14);
        chk("pos.frame_period", first_from(l_fs0, 1, 1'b1), 32'd98);
        chk("pos.fc_before",    l_fc0[97], 32'd0);
        chk("pos.fc_after",     l_fc0[98], 32'd1);
        chk("neg.hs_idle",      32'(l_hs1[0]), 32'd1);
        chk("neg.vs_idle",      32'(l_vs1[0]), 32'd1);
        chk("neg.hs_start",     first_from(l_hs1, 0, 1'b0), 32'd10);
        chk("neg.hs_width",     run_len(l_hs1, 10, 1'b0), 32'd2);
        chk("neg.vs_start",     first_from(l_vs1, 0, 1'b0), 32'd70);
        chk("neg.vs_width",     run_len(l_vs1, 70, 1'b0), 32'd14);

        // Reset in the middle of a line at x=5
        step(1'b1, 1'b0);
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            step(1'b0, 1'b1);
            if (act[0].de && act[0].x == 11'd5) found = 1;
        end
        chk("mid.found_x5", found, 32'd1);
        step(1'b1, 1'b1);
        chk("mid.de_reset", 32'(act[0].de), 32'd0);
        chk("mid.x_reset",  32'(act[0].x),  32'd0);
        step(1'b0, 1'b1);
        chk("mid.restart_fs", 32'(act[0].fs), 32'd1);
        chk("mid.restart_fc", 32'(act[0].fc), 32'd0);

        // ce toggling 1,0,1,0: the model expects a stretched timeline with one-clk strobes
        step(1'b1, 1'b0);
        for (int k = 0; k < 240; k++) begin
            step(1'b0, (k % 2) == 0);
        end

        // Fast-forward 256 frames of the small mode: frame_cnt wraps 255 -> 0
        step(1'b1, 1'b0);
        for (int k = 0; k < 256 * 98; k++) begin
            step(1'b0, 1'b1);
        end
        fc_before = act[0].fc;
        chk("wrap.fc_255", 32'(fc_before), 32'd255);
        step(1'b0, 1'b1);
        chk("wrap.fc_0", 32'(act[0].fc), 32'd0);
        chk("wrap.fs",   32'(act[0].fs), 32'd1);

        // Randomised ce with occasional reset pulses
        for (int k = 0; k < 2500; k++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
